// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage LSU (master) and the data memory (slave).
// The master holds req/we/addr/wdata/be stable until the slave returns ack.
// The slave drives rdata together with ack.
interface mem_stage_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: passes ALU results through in one cycle.
// Memory ops go through IDLE -> REQ -> RESP.
// Optional feature macro: LSU_MISALIGN_TRAP_EN adds o_misaligned.
// With it, misaligned half/word accesses complete at once with no bus request.
module mem_stage_lsu (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ex_valid,
  output logic        o_ex_ready,
  input  logic        i_ex_rmem,
  input  logic        i_ex_wmem,
  input  logic [1:0]  i_ex_size,
  input  logic        i_ex_unsigned,
  input  logic        i_ex_mem2reg,
  input  logic        i_ex_wreg,
  input  logic [4:0]  i_ex_rd,
  input  logic [31:0] i_ex_alu,
  input  logic [31:0] i_ex_wdata,
  mem_stage_lsu_if.master dmem,
  output logic        o_mem_valid,
  output logic        o_mem_mem2reg,
  output logic        o_mem_wreg,
  output logic [4:0]  o_mem_rd,
  output logic [31:0] o_mem_data,
  output logic [31:0] o_rd_dmem,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        o_misaligned,
`endif
  output logic        o_stall
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state;
  logic        ent_we_p1;
  logic [1:0]  ent_size_p1;
  logic        ent_uns_p1;
  logic        ent_m2r_p1;
  logic        ent_wreg_p1;
  logic [4:0]  ent_rd_p1;
  logic [31:0] ent_alu_p1;
  logic [31:0] rdata_p2;
  logic        is_mem;

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   be_gen = 4'b0001 << lo;
      2'b01:   be_gen = lo[1] ? 4'b1100 : 4'b0011;
      default: be_gen = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_gen(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   wdata_gen = {4{wd[7:0]}};
      2'b01:   wdata_gen = {2{wd[15:0]}};
      default: wdata_gen = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] size, input logic uns,
                                           input logic [1:0] lo, input logic [31:0] rdata);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    sb = 8'(rdata >> {lo, 3'b000});
    sh = 16'(rdata >> {lo[1], 4'b0000});
    case (size)
      2'b00:   load_ext = uns ? {24'b0, sb} : 32'(sb);
      2'b01:   load_ext = uns ? {16'b0, sh} : 32'(sh);
      default: load_ext = rdata;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    misaligned = ((size == 2'b01) && lo[0]) || (size[1] && (lo != 2'b00));
  endfunction
`endif

  assign is_mem     = i_ex_rmem | i_ex_wmem;
  assign o_ex_ready = (state == S_IDLE);
  assign o_stall    = (state != S_IDLE);

  // Entry and response latches: data only, loaded on accept / ack.
  always_ff @(posedge i_clk) begin
    if (state == S_IDLE && i_ex_valid) begin
      ent_we_p1   <= i_ex_wmem;
      ent_size_p1 <= i_ex_size;
      ent_uns_p1  <= i_ex_unsigned;
      ent_m2r_p1  <= i_ex_mem2reg;
      ent_wreg_p1 <= i_ex_wreg;
      ent_rd_p1   <= i_ex_rd;
      ent_alu_p1  <= i_ex_alu;
    end
    if (state == S_REQ && dmem.ack) rdata_p2 <= dmem.rdata;
  end

  // FSM, memory request fields and MEM/WB outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= S_IDLE;
      dmem.req      <= 1'b0;
      dmem.we       <= 1'b0;
      dmem.addr     <= '0;
      dmem.wdata    <= '0;
      dmem.be       <= '0;
      o_mem_valid   <= 1'b0;
      o_mem_mem2reg <= 1'b0;
      o_mem_wreg    <= 1'b0;
      o_mem_rd      <= '0;
      o_mem_data    <= '0;
      o_rd_dmem     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      o_misaligned  <= 1'b0;
`endif
    end else begin
      o_mem_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_ex_valid) begin
            if (!is_mem) begin
              o_mem_valid   <= 1'b1;
              o_mem_mem2reg <= i_ex_mem2reg;
              o_mem_wreg    <= i_ex_wreg;
              o_mem_rd      <= i_ex_rd;
              o_mem_data    <= i_ex_alu;
`ifdef LSU_MISALIGN_TRAP_EN
              o_misaligned  <= 1'b0;
`endif
            end
`ifdef LSU_MISALIGN_TRAP_EN
            else if (misaligned(i_ex_size, i_ex_alu[1:0])) begin
              o_mem_valid   <= 1'b1;
              o_mem_mem2reg <= i_ex_mem2reg;
              o_mem_wreg    <= 1'b0;
              o_mem_rd      <= i_ex_rd;
              o_mem_data    <= i_ex_alu;
              o_misaligned  <= 1'b1;
            end
`endif
            else begin
              state      <= S_REQ;
              dmem.req   <= 1'b1;
              dmem.we    <= i_ex_wmem;
              dmem.addr  <= {i_ex_alu[31:2], 2'b00};
              dmem.wdata <= wdata_gen(i_ex_size, i_ex_wdata);
              dmem.be    <= be_gen(i_ex_size, i_ex_alu[1:0]);
            end
          end
        end
        S_REQ: begin
          if (dmem.ack) begin
            state    <= S_RESP;
            dmem.req <= 1'b0;
          end
        end
        S_RESP: begin
          state         <= S_IDLE;
          o_mem_valid   <= 1'b1;
          o_mem_mem2reg <= ent_m2r_p1;
          o_mem_wreg    <= ent_wreg_p1 & ~ent_we_p1;
          o_mem_rd      <= ent_rd_p1;
          o_mem_data    <= ent_alu_p1;
          o_rd_dmem     <= ent_we_p1 ? 32'h0
                         : load_ext(ent_size_p1, ent_uns_p1, ent_alu_p1[1:0], rdata_p2);
`ifdef LSU_MISALIGN_TRAP_EN
          o_misaligned  <= 1'b0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
